// File: rtl/pg_seq_pkg.sv
// Shared types and constants for the pass-gate enable sequencer.
// Segment codes give the (INN, INP) pair for a fully off and a fully on pass gate.
package pg_seq_pkg;

    typedef enum logic [2:0] {
        PG_OFF,
        PG_PU_N,
        PG_PU_P,
        PG_PU_GAP,
        PG_ON,
        PG_PD_P,
        PG_PD_N,
        PG_PD_GAP
    } pg_state_t;

    localparam int PG_DEAD_CYC_DEF    = 2;
    localparam int PG_STAGGER_CYC_DEF = 8;

    typedef struct packed {
        logic inn;
        logic inp;
    } pg_seg_code_t;

    localparam pg_seg_code_t PG_SEG_OFF = '{inn: 1'b0, inp: 1'b1};
    localparam pg_seg_code_t PG_SEG_ON  = '{inn: 1'b1, inp: 1'b0};

endpackage

// File: rtl/pg_dly_cnt.sv
// Loadable down-counter; expire pulses for the single cycle the count sits at 1,
// so a value L loaded on edge e is acted on at edge e+L.
module pg_dly_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expire
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign expire = (cnt == CNT_W'(1));

endmodule

// File: rtl/pg_seq.sv
// Pass-gate enable sequencer: staggered, break-before-make power-up/down of N_SEG segments.
// Optional macro PG_SEG_STATUS_EN adds the registered per-segment on-status output seg_on.
module pg_seq
    import pg_seq_pkg::*;
#(
    parameter int N_SEG       = 4,
    parameter int DEAD_CYC    = PG_DEAD_CYC_DEF,
    parameter int STAGGER_CYC = PG_STAGGER_CYC_DEF,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwr_req,
    output logic             pwr_ack,
    output logic             busy,
    output logic [N_SEG-1:0] seg_inn,
    output logic [N_SEG-1:0] seg_inp,
    output pg_state_t        dbg_state
`ifdef PG_SEG_STATUS_EN
    ,
    output logic [N_SEG-1:0] seg_on
`endif
);

    localparam int IDX_W = (N_SEG > 1) ? $clog2(N_SEG) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_SEG - 1);

    pg_state_t          state, state_d;
    logic [IDX_W-1:0]   idx, idx_d, idx_nxt, idx_prv;
    logic [N_SEG-1:0]   inn_d, inp_d;
    logic               ack_d, busy_d;
    logic               load;
    logic [CNT_W-1:0]   load_val;
    logic               expire;

    pg_dly_cnt #(.CNT_W(CNT_W)) u_dly (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .expire   (expire)
    );

    assign idx_nxt   = idx + IDX_W'(1);
    assign idx_prv   = idx - IDX_W'(1);
    assign dbg_state = state;

    // Abort during power-up wins over a same-cycle counter expiry.
    always_comb begin
        state_d  = state;
        idx_d    = idx;
        inn_d    = seg_inn;
        inp_d    = seg_inp;
        ack_d    = pwr_ack;
        load     = 1'b0;
        load_val = '0;
        case (state)
            PG_OFF: begin
                if (pwr_req) begin
                    idx_d    = '0;
                    inn_d[0] = PG_SEG_ON.inn;
                    state_d  = PG_PU_N;
                    load     = 1'b1;
                    load_val = CNT_W'(DEAD_CYC);
                end
            end
            PG_PU_N: begin
                if (!pwr_req) begin
                    state_d  = PG_PD_P;
                    load     = 1'b1;
                    load_val = CNT_W'(DEAD_CYC);
                end else if (expire) begin
                    inp_d[idx] = PG_SEG_ON.inp;
                    if (idx == LAST) begin
                        state_d = PG_ON;
                    end else begin
                        state_d  = PG_PU_GAP;
                        load     = 1'b1;
                        load_val = CNT_W'(STAGGER_CYC);
                    end
                end
            end
            PG_PU_GAP: begin
                if (!pwr_req) begin
                    inp_d[idx] = PG_SEG_OFF.inp;
                    state_d    = PG_PD_P;
                    load       = 1'b1;
                    load_val   = CNT_W'(DEAD_CYC);
                end else if (expire) begin
                    idx_d          = idx_nxt;
                    inn_d[idx_nxt] = PG_SEG_ON.inn;
                    state_d        = PG_PU_N;
                    load           = 1'b1;
                    load_val       = CNT_W'(DEAD_CYC);
                end
            end
            PG_ON: begin
                if (!pwr_req) begin
                    ack_d       = 1'b0;
                    idx_d       = LAST;
                    inp_d[LAST] = PG_SEG_OFF.inp;
                    state_d     = PG_PD_P;
                    load        = 1'b1;
                    load_val    = CNT_W'(DEAD_CYC);
                end else begin
                    ack_d = 1'b1;
                end
            end
            PG_PD_P: begin
                if (expire) begin
                    inn_d[idx] = PG_SEG_OFF.inn;
                    if (idx == '0) begin
                        state_d = PG_OFF;
                    end else begin
                        state_d  = PG_PD_GAP;
                        load     = 1'b1;
                        load_val = CNT_W'(STAGGER_CYC);
                    end
                end
            end
            PG_PD_GAP: begin
                if (expire) begin
                    idx_d          = idx_prv;
                    inp_d[idx_prv] = PG_SEG_OFF.inp;
                    state_d        = PG_PD_P;
                    load           = 1'b1;
                    load_val       = CNT_W'(DEAD_CYC);
                end
            end
            default: begin
                state_d = PG_OFF;
                idx_d   = '0;
                inn_d   = {N_SEG{PG_SEG_OFF.inn}};
                inp_d   = {N_SEG{PG_SEG_OFF.inp}};
                ack_d   = 1'b0;
            end
        endcase
        // Busy stays up on entry to ON until the acknowledge is actually raised.
        busy_d = (state_d != PG_OFF) && !ack_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= PG_OFF;
            idx     <= '0;
            seg_inn <= {N_SEG{PG_SEG_OFF.inn}};
            seg_inp <= {N_SEG{PG_SEG_OFF.inp}};
            pwr_ack <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_d;
            idx     <= idx_d;
            seg_inn <= inn_d;
            seg_inp <= inp_d;
            pwr_ack <= ack_d;
            busy    <= busy_d;
        end
    end

`ifdef PG_SEG_STATUS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_on <= '0;
        end else begin
            seg_on <= seg_inn & ~seg_inp;
        end
    end
`endif

endmodule

// File: tb/tb_pg_seq.sv
// Bench for pg_seq: directed timing scenarios plus random request toggling against
// an event-time model of the segments; PG_SEG_STATUS_EN also checks seg_on.
module tb_pg_seq;
    import pg_seq_pkg::*;

    localparam int N       = 4;
    localparam int DEAD    = 2;
    localparam int STAGGER = 8;
    localparam int M_OFF = 0, M_UP = 1, M_ON = 2, M_DN = 3;

    logic         clk, rst, pwr_req;
    logic         pwr_ack, busy;
    logic [N-1:0] seg_inn, seg_inp;
    pg_state_t    dbg_state;
`ifdef PG_SEG_STATUS_EN
    logic [N-1:0] seg_on;
`endif

    pg_seq #(.N_SEG(N), .DEAD_CYC(DEAD), .STAGGER_CYC(STAGGER), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .pwr_req   (pwr_req),
        .pwr_ack   (pwr_ack),
        .busy      (busy),
        .seg_inn   (seg_inn),
        .seg_inp   (seg_inp),
        .dbg_state (dbg_state)
`ifdef PG_SEG_STATUS_EN
        ,
        .seg_on    (seg_on)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // reference model: segment codes plus the absolute cycle of the next action
    int           m_mode, m_now, m_next;
    logic [N-1:0] m_inn, m_inp;
    logic         m_ack;

    function automatic int top_on(input logic [N-1:0] v);
        int r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        int j;
        if (rst) begin
            m_mode = M_OFF; m_now = 0; m_next = 0;
            m_inn = '0; m_inp = '1; m_ack = 1'b0;
        end else begin
            m_now++;
            case (m_mode)
                M_OFF: if (pwr_req) begin
                    m_inn[0] = 1'b1; m_mode = M_UP; m_next = m_now + DEAD;
                end
                M_UP: begin
                    j = top_on(m_inn);
                    if (!pwr_req) begin
                        m_inp[j] = 1'b1; m_mode = M_DN; m_next = m_now + DEAD;
                    end else if (m_now == m_next) begin
                        if (m_inp[j]) begin
                            m_inp[j] = 1'b0;
                            if (j == N - 1) m_mode = M_ON;
                            else m_next = m_now + STAGGER;
                        end else begin
                            m_inn[j+1] = 1'b1; m_next = m_now + DEAD;
                        end
                    end
                end
                M_ON: begin
                    if (!pwr_req) begin
                        m_ack = 1'b0; m_inp[N-1] = 1'b1; m_mode = M_DN; m_next = m_now + DEAD;
                    end else begin
                        m_ack = 1'b1;
                    end
                end
                default: if (m_now == m_next) begin
                    j = top_on(m_inn);
                    if (m_inp[j]) begin
                        m_inn[j] = 1'b0;
                        if (j == 0) m_mode = M_OFF;
                        else m_next = m_now + STAGGER;
                    end else begin
                        m_inp[j] = 1'b1; m_next = m_now + DEAD;
                    end
                end
            endcase
        end
    end

    // scoreboard: per-cycle model compare plus structural invariants
    logic         chk_en = 1'b0;
    logic         rst_seen = 1'b1;
    logic [N-1:0] p_inn = '0, p_inp = '1;

    always @(negedge clk) begin
        logic bbm_ok, ord_ok, skip;
        if (chk_en) begin
            check("inn", 32'(seg_inn), 32'(m_inn));
            check("inp", 32'(seg_inp), 32'(m_inp));
            check("ack", 32'(pwr_ack), 32'(m_ack));
            check("busy", 32'(busy), 32'((m_mode == M_UP) || (m_mode == M_DN) ||
                                         (m_mode == M_ON && !m_ack)));
            skip = rst || rst_seen;
            if (!skip) begin
                bbm_ok = 1'b1;
                for (int s = 0; s < N; s++)
                    if (((seg_inn[s] ^ p_inn[s]) + (seg_inp[s] ^ p_inp[s])) > 1) bbm_ok = 1'b0;
                check("break_before_make", 32'(bbm_ok), 32'(1));
            end
            ord_ok = 1'b1;
            for (int j = 1; j < N; j++)
                if (seg_inn[j] && !seg_inp[j])
                    for (int i = 0; i < j; i++)
                        if (!(seg_inn[i] && !seg_inp[i])) ord_ok = 1'b0;
            check("order", 32'(ord_ok), 32'(1));
`ifdef PG_SEG_STATUS_EN
            check("seg_on", 32'(seg_on), rst ? 32'(0) : 32'(p_inn & ~p_inp));
`endif
        end
        rst_seen = rst;
        p_inn = seg_inn;
        p_inp = seg_inp;
    end
    always @(posedge rst) rst_seen = 1'b1;

    // driver tasks
    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic set_req(input logic v, output int e);
        @(negedge clk);
        pwr_req = v;
        e = cyc + 1;
    endtask

    int e0, e1;

    initial begin
        rst = 1'b1;
        pwr_req = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        chk_en = 1'b1;
        check("rst_inn", 32'(seg_inn), 32'(0));
        check("rst_inp", 32'(seg_inp), 32'hF);
        check("rst_state", 32'(dbg_state), 32'(PG_OFF));
        repeat (20) @(negedge clk);
        check("idle_ack", 32'(pwr_ack), 32'(0));
        check("idle_busy", 32'(busy), 32'(0));

        // power-up timing
        set_req(1'b1, e0);
        wait_until(e0);      check("pu_inn0", 32'(seg_inn), 32'h1);
                             check("pu_busy", 32'(busy), 32'(1));
        wait_until(e0 + 1);  check("pu_inp_hold", 32'(seg_inp), 32'hF);
        wait_until(e0 + 2);  check("pu_inp0", 32'(seg_inp), 32'hE);
        wait_until(e0 + 10); check("pu_inn1", 32'(seg_inn), 32'h3);
        wait_until(e0 + 31); check("pu_inp_31", 32'(seg_inp), 32'h8);
        wait_until(e0 + 32); check("pu_inp_32", 32'(seg_inp), 32'h0);
                             check("pu_ack_32", 32'(pwr_ack), 32'(0));
                             check("pu_busy_32", 32'(busy), 32'(1));
        wait_until(e0 + 33); check("pu_ack_33", 32'(pwr_ack), 32'(1));
                             check("pu_busy_33", 32'(busy), 32'(0));
        repeat (5) @(negedge clk);

        // power-down timing
        set_req(1'b0, e1);
        wait_until(e1);      check("pd_ack", 32'(pwr_ack), 32'(0));
                             check("pd_inp3", 32'(seg_inp), 32'h8);
        wait_until(e1 + 2);  check("pd_inn3", 32'(seg_inn), 32'h7);
        wait_until(e1 + 10); check("pd_inp2", 32'(seg_inp), 32'hC);
        wait_until(e1 + 31); check("pd_busy_31", 32'(busy), 32'(1));
        wait_until(e1 + 32); check("pd_inn_32", 32'(seg_inn), 32'h0);
                             check("pd_busy_32", 32'(busy), 32'(0));
                             check("pd_state", 32'(dbg_state), 32'(PG_OFF));
        repeat (5) @(negedge clk);

        // abort with segment 1 fully on
        set_req(1'b1, e0);
        wait_until(e0 + 12);
        pwr_req = 1'b0;
        wait_until(e0 + 13); check("ab_inp1", 32'(seg_inp), 32'hE);
        wait_until(e0 + 15); check("ab_inn1", 32'(seg_inn), 32'h1);
        wait_until(e0 + 23); check("ab_inp0", 32'(seg_inp), 32'hF);
        wait_until(e0 + 25); check("ab_inn0", 32'(seg_inn), 32'h0);
                             check("ab_ack", 32'(pwr_ack), 32'(0));
                             check("ab_busy", 32'(busy), 32'(0));
        repeat (5) @(negedge clk);

        // reset mid power-up, request held
        set_req(1'b1, e0);
        wait_until(e0 + 20);
        #2 rst = 1'b1;
        #1 check("mr_inn", 32'(seg_inn), 32'h0);
        check("mr_inp", 32'(seg_inp), 32'hF);
        check("mr_state", 32'(dbg_state), 32'(PG_OFF));
        check("mr_busy", 32'(busy), 32'(0));
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("mr_restart", 32'(seg_inn), 32'h1);
        wait_until(cyc + 40);

        // random request toggling
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            pwr_req = ($urandom_range(0, 1) == 1);
            repeat ($urandom_range(1, 50)) @(negedge clk);
        end
        pwr_req = 1'b0;
        repeat (60) @(negedge clk);
        check("end_state", 32'(dbg_state), 32'(PG_OFF));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not complete, cycle %0d", cyc);
        $fatal(1);
    end

endmodule
